// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SPI register bridge.
//   state_e     : bridge FSM encoding (IDLE=0, FWD=1, RESP=2, DONE=3)
//   rsp_e       : slave termination selected for the RESP cycle
//   OFF_STATUS  : local status register offset inside the 8-register window
//   OFF_CTRL    : local control register offset
//   status_byte : packs the STATUS read value
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2,
    RSP_RTY  = 2'd3
  } rsp_e;

  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CTRL   = 3'd5;

  function automatic logic [7:0] status_byte(input logic [3:0] to_cnt,
                                             input logic       to_flag,
                                             input logic       inta);
    return {to_cnt, 2'b00, to_flag, inta};
  endfunction

endpackage

// File: rtl/wb_bridge_timeout.sv
// SPI-ack timeout timer: a loadable down-counter.
//   clk_i    : clock (rising edge)
//   rst_i    : synchronous reset, active-high (counter -> 0)
//   load_i   : reload with TIMEOUT-1
//   en_i     : count down while waiting for the SPI ack
//   expire_o : high in the enabled cycle where the count has reached zero,
//              i.e. the TIMEOUT-th cycle after the load
module wb_bridge_timeout #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TO_W'(TIMEOUT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = en_i & ~load_i & (cnt_q == '0);

endmodule

// File: rtl/wb_spi_bus_bridge.sv
// Wishbone slave (from the I2C master) to Wishbone master (SPI core) bridge.
// Window of 8 registers at BASE_ADDR: offsets 0-3 go to SPI regs 0-3,
// offset 4 is STATUS, offset 5 is CTRL, anything else terminates with err.
//   wb_clk_i/wb_rst_i : clock, synchronous active-high reset
//   s_*               : slave port; ack/err/rty are registered 1-cycle pulses
//   m_*               : SPI master port; m_cyc_o and m_stb_o move together
//   m_inta_i/irq_o    : SPI interrupt, gated by CTRL bit0
module wb_spi_bus_bridge
  import wb_bridge_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned TO_W      = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] s_adr_i,
  input  logic [7:0] s_dat_i,
  output logic [7:0] s_dat_o,
  input  logic [3:0] s_sel_i,
  input  logic       s_we_i,
  input  logic       s_cyc_i,
  input  logic       s_stb_i,
  output logic       s_ack_o,
  output logic       s_err_o,
  output logic       s_rty_o,
  output logic [1:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  output logic       m_we_o,
  output logic       m_cyc_o,
  output logic       m_stb_o,
  input  logic       m_ack_i,
  input  logic       m_inta_i,
  output logic       irq_o
);

  state_e     state_q, state_d;
  rsp_e       rsp_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic       we_q, we_d;
  logic       mcyc_q, mcyc_d;
  logic       ack_q, err_q, rty_q;
  logic [7:0] sdat_q, sdat_d;
  logic       ctrl_q, ctrl_d;
  logic [3:0] to_cnt_q, to_cnt_d;
  logic       to_flag_q, to_flag_d;
  logic       expire;

  logic       hit;
  logic [2:0] off;
  logic       unused_sel;

  assign hit        = (s_adr_i[7:3] == BASE_ADDR[7:3]);
  assign off        = s_adr_i[2:0];
  assign unused_sel = ^s_sel_i[3:1];

  wb_bridge_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .load_i   (state_q == IDLE),
    .en_i     (state_q == FWD),
    .expire_o (expire)
  );

  always_comb begin
    state_d   = state_q;
    rsp_d     = RSP_NONE;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    mcyc_d    = mcyc_q;
    sdat_d    = 8'h00;
    ctrl_d    = ctrl_q;
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    unique case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          state_d = RESP;
          if (hit && s_sel_i[0] && !off[2]) begin
            adr_d   = off[1:0];
            dat_d   = s_dat_i;
            we_d    = s_we_i;
            mcyc_d  = 1'b1;
            state_d = FWD;
          end else if (hit && s_sel_i[0] && (off == OFF_STATUS || off == OFF_CTRL)) begin
            rsp_d = RSP_ACK;
            if (s_we_i) begin
              if (off == OFF_STATUS) begin
                to_cnt_d  = 4'd0;
                to_flag_d = 1'b0;
              end else begin
                ctrl_d = s_dat_i[0];
              end
            end else begin
              sdat_d = (off == OFF_STATUS) ? status_byte(to_cnt_q, to_flag_q, m_inta_i)
                                           : {7'b0, ctrl_q};
            end
          end else begin
            rsp_d = RSP_ERR;
          end
        end
      end
      FWD: begin
        // Abort has priority over a coincident ack or timeout.
        if (!s_cyc_i) begin
          mcyc_d  = 1'b0;
          state_d = IDLE;
        end else if (m_ack_i) begin
          mcyc_d  = 1'b0;
          rsp_d   = RSP_ACK;
          sdat_d  = we_q ? 8'h00 : m_dat_i;
          state_d = RESP;
        end else if (expire) begin
          mcyc_d    = 1'b0;
          rsp_d     = RSP_RTY;
          to_flag_d = 1'b1;
          if (to_cnt_q != 4'hF) to_cnt_d = to_cnt_q + 4'd1;
          state_d   = RESP;
        end
      end
      RESP: state_d = DONE;
      DONE: if (!s_stb_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      mcyc_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      sdat_q    <= '0;
      ctrl_q    <= 1'b0;
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      mcyc_q    <= mcyc_d;
      ack_q     <= (rsp_d == RSP_ACK);
      err_q     <= (rsp_d == RSP_ERR);
      rty_q     <= (rsp_d == RSP_RTY);
      sdat_q    <= sdat_d;
      ctrl_q    <= ctrl_d;
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign s_dat_o = sdat_q;
  assign s_ack_o = ack_q;
  assign s_err_o = err_q;
  assign s_rty_o = rty_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign m_we_o  = we_q;
  assign m_cyc_o = mcyc_q;
  assign m_stb_o = mcyc_q;
  assign irq_o   = ctrl_q & m_inta_i;

endmodule

// File: tb/tb_wb_spi_bus_bridge.sv
module tb_wb_spi_bus_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_adr = '0, s_dat_in = '0;
  logic [7:0] s_dat_o;
  logic [3:0] s_sel = '0;
  logic       s_we = 1'b0, s_cyc = 1'b0, s_stb = 1'b0;
  logic       s_ack_o, s_err_o, s_rty_o;
  logic [1:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] spi_rdata = '0;
  logic       m_we_o, m_cyc_o, m_stb_o;
  logic       spi_ack = 1'b0, inj_ack = 1'b0;
  logic       m_ack;
  logic       inta = 1'b0;
  logic       irq_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  // SPI responder state
  int         spi_delay = 0;   // 0 = never ack
  int         spi_cnt = 0;
  int         mcyc_total = 0;
  logic [1:0] seen_adr = '0;
  logic [7:0] seen_dat = '0;
  logic       seen_we = 1'b0;
  logic       seen_stb = 1'b0;

  assign m_ack = spi_ack | inj_ack;

  wb_spi_bus_bridge #(.BASE_ADDR(8'h00), .TIMEOUT(16), .TO_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .s_adr_i  (s_adr),
    .s_dat_i  (s_dat_in),
    .s_dat_o  (s_dat_o),
    .s_sel_i  (s_sel),
    .s_we_i   (s_we),
    .s_cyc_i  (s_cyc),
    .s_stb_i  (s_stb),
    .s_ack_o  (s_ack_o),
    .s_err_o  (s_err_o),
    .s_rty_o  (s_rty_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_dat_i  (spi_rdata),
    .m_we_o   (m_we_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_ack_i  (m_ack),
    .m_inta_i (inta),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (m_cyc_o) begin
        mcyc_total++;
        spi_cnt++;
        if (spi_cnt == 1) begin
          seen_adr = m_adr_o;
          seen_dat = m_dat_o;
          seen_we  = m_we_o;
          seen_stb = m_stb_o;
        end
        spi_ack = (spi_cnt == spi_delay);
      end else begin
        spi_cnt = 0;
        spi_ack = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_start(input logic [7:0] adr, input logic [7:0] dat,
                           input logic we, input logic [3:0] sel);
    s_adr = adr; s_dat_in = dat; s_we = we; s_sel = sel;
    s_cyc = 1'b1; s_stb = 1'b1;
  endtask

  task automatic wait_term(output logic [2:0] term, output logic [7:0] rdat,
                           output int ncyc);
    term = '0; rdat = '0; ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      ncyc++;
      if (s_ack_o | s_err_o | s_rty_o) begin
        term = {s_ack_o, s_err_o, s_rty_o};
        rdat = s_dat_o;
        break;
      end
    end
  endtask

  task automatic bus_end();
    s_cyc = 1'b0; s_stb = 1'b0;
    tick(); tick();
  endtask

  task automatic access(input logic [7:0] adr, input logic [7:0] dat, input logic we,
                        input logic [3:0] sel, output logic [2:0] term,
                        output logic [7:0] rdat, output int ncyc);
    bus_start(adr, dat, we, sel);
    wait_term(term, rdat, ncyc);
    bus_end();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if ({s_dat_o, s_ack_o, s_err_o, s_rty_o, m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o} !== 24'h0)
      $display("FAIL reset_outputs: got dat=%h ack=%b err=%b rty=%b madr=%h mdat=%h we=%b cyc=%b stb=%b, want all 0",
               s_dat_o, s_ack_o, s_err_o, s_rty_o, m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o);
    else pass_cnt++;
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_o);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fwd_write();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    spi_delay = 3;
    access(8'h01, 8'h5A, 1'b1, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if ({seen_adr, seen_dat, seen_we, seen_stb} !== {2'd1, 8'h5A, 1'b1, 1'b1})
      $display("FAIL fwd_write_master: got adr=%h dat=%h we=%b stb=%b want adr=1 dat=5a we=1 stb=1",
               seen_adr, seen_dat, seen_we, seen_stb);
    else pass_cnt++;
    total_cnt++;
    if (term !== 3'b100) $display("FAIL fwd_write_term: got ack/err/rty=%b want 100", term);
    else pass_cnt++;
    total_cnt++;
    if (ncyc !== 4) $display("FAIL fwd_write_latency: got %0d want 4", ncyc);
    else pass_cnt++;
    total_cnt++;
    if (s_ack_o !== 1'b0) $display("FAIL fwd_write_ack_pulse: ack still %b after RESP, want 0", s_ack_o);
    else pass_cnt++;
  endtask

  task automatic test_fwd_read();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    spi_delay = 1;
    spi_rdata = 8'hC3;
    bus_start(8'h00, 8'h00, 1'b0, 4'b0001);
    wait_term(term, rdat, ncyc);
    total_cnt++;
    if (m_cyc_o !== 1'b0) $display("FAIL fwd_read_cyc_drop: got m_cyc=%b want 0", m_cyc_o);
    else pass_cnt++;
    bus_end();
    total_cnt++;
    if ({term, rdat} !== {3'b100, 8'hC3})
      $display("FAIL fwd_read_data: got term=%b dat=%h want term=100 dat=c3", term, rdat);
    else pass_cnt++;
    total_cnt++;
    if (ncyc !== 2) $display("FAIL fwd_read_latency: got %0d want 2", ncyc);
    else pass_cnt++;
    spi_rdata = 8'h00;
  endtask

  task automatic test_timeout();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    spi_delay = 0;
    mcyc_total = 0;
    access(8'h02, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if ({term, rdat} !== {3'b001, 8'h00})
      $display("FAIL timeout_rty: got term=%b dat=%h want term=001 dat=00", term, rdat);
    else pass_cnt++;
    total_cnt++;
    if (mcyc_total !== 16) $display("FAIL timeout_cyc_len: m_cyc high %0d cycles, want 16", mcyc_total);
    else pass_cnt++;
    total_cnt++;
    if (ncyc !== 17) $display("FAIL timeout_latency: got %0d want 17", ncyc);
    else pass_cnt++;
    access(8'h04, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if ({term, rdat} !== {3'b100, 8'h12})
      $display("FAIL timeout_status: got term=%b dat=%h want term=100 dat=12", term, rdat);
    else pass_cnt++;
    total_cnt++;
    if (ncyc !== 1) $display("FAIL local_latency: got %0d want 1", ncyc);
    else pass_cnt++;
  endtask

  task automatic test_err();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    logic [7:0] adrs [4];
    logic [3:0] sels [4];
    adrs = '{8'h06, 8'h40, 8'h01, 8'h45};
    sels = '{4'b0001, 4'b0001, 4'b0010, 4'b0001};
    mcyc_total = 0;
    spi_delay = 1;
    for (int i = 0; i < 4; i++) begin
      access(adrs[i], 8'hFF, 1'b1, sels[i], term, rdat, ncyc);
      total_cnt++;
      if ({term, rdat} !== {3'b010, 8'h00})
        $display("FAIL err_case%0d: adr=%h sel=%b got term=%b dat=%h want term=010 dat=00",
                 i, adrs[i], sels[i], term, rdat);
      else pass_cnt++;
    end
    total_cnt++;
    if (mcyc_total !== 0) $display("FAIL err_no_fwd: m_cyc high %0d cycles, want 0", mcyc_total);
    else pass_cnt++;
    access(8'h05, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if ({term, rdat} !== {3'b100, 8'h00})
      $display("FAIL err_no_side_effect: CTRL got term=%b dat=%h want term=100 dat=00", term, rdat);
    else pass_cnt++;
  endtask

  task automatic test_irq_ctrl();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    inta = 1'b1;
    access(8'h05, 8'hFF, 1'b1, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL irq_enabled: got %b want 1", irq_o);
    else pass_cnt++;
    access(8'h05, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if (rdat !== 8'h01) $display("FAIL ctrl_read: got %h want 01", rdat);
    else pass_cnt++;
    inta = 1'b0; #1;
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL irq_level_follow: got %b want 0", irq_o);
    else pass_cnt++;
    inta = 1'b1;
    access(8'h05, 8'h00, 1'b1, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL irq_disabled: got %b want 0", irq_o);
    else pass_cnt++;
    access(8'h04, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if (rdat !== 8'h13) $display("FAIL status_inta: got %h want 13", rdat);
    else pass_cnt++;
    access(8'h04, 8'h00, 1'b1, 4'b0001, term, rdat, ncyc);
    access(8'h04, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if (rdat !== 8'h01) $display("FAIL status_clear: got %h want 01", rdat);
    else pass_cnt++;
    inta = 1'b0;
  endtask

  task automatic test_saturate();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    int rty_seen = 0;
    spi_delay = 0;
    for (int i = 0; i < 16; i++) begin
      access(8'h03, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
      if (term == 3'b001) rty_seen++;
    end
    total_cnt++;
    if (rty_seen !== 16) $display("FAIL sat_rty_count: got %0d retries want 16", rty_seen);
    else pass_cnt++;
    access(8'h04, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if (rdat !== 8'hF2) $display("FAIL status_saturate: got %h want f2", rdat);
    else pass_cnt++;
    access(8'h04, 8'h00, 1'b1, 4'b0001, term, rdat, ncyc);
    access(8'h04, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if (rdat !== 8'h00) $display("FAIL status_clear_sat: got %h want 00", rdat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    bus_start(8'h05, 8'h01, 1'b1, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_ack_o) acks++;
    end
    bus_end();
    total_cnt++;
    if (acks !== 1) $display("FAIL held_stb_single: got %0d acks want 1", acks);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    int terms = 0;
    spi_delay = 0;
    spi_rdata = 8'hAA;
    bus_start(8'h02, 8'h00, 1'b0, 4'b0001);
    tick(); tick();
    s_cyc = 1'b0; s_stb = 1'b0;
    tick();
    total_cnt++;
    if (m_cyc_o !== 1'b0) $display("FAIL abort_cyc_drop: got m_cyc=%b want 0", m_cyc_o);
    else pass_cnt++;
    inj_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      inj_ack = 1'b0;
      if (s_ack_o | s_err_o | s_rty_o) terms++;
    end
    total_cnt++;
    if (terms !== 0) $display("FAIL abort_no_term: got %0d terminations want 0", terms);
    else pass_cnt++;
    spi_rdata = 8'h00;
    access(8'h05, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if ({term, rdat} !== {3'b100, 8'h01})
      $display("FAIL abort_recover: got term=%b dat=%h want term=100 dat=01", term, rdat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [2:0] term; logic [7:0] rdat; int ncyc;
    spi_delay = 0;
    bus_start(8'h03, 8'h77, 1'b1, 4'b0001);
    tick(); tick(); tick();
    total_cnt++;
    if ({m_cyc_o, m_adr_o, m_dat_o, m_we_o} !== {1'b1, 2'd3, 8'h77, 1'b1})
      $display("FAIL mid_fwd_active: got cyc=%b adr=%h dat=%h we=%b want cyc=1 adr=3 dat=77 we=1",
               m_cyc_o, m_adr_o, m_dat_o, m_we_o);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({s_dat_o, s_ack_o, s_err_o, s_rty_o, m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o} !== 24'h0)
      $display("FAIL mid_reset_outputs: got dat=%h ack=%b err=%b rty=%b madr=%h mdat=%h we=%b cyc=%b stb=%b, want all 0",
               s_dat_o, s_ack_o, s_err_o, s_rty_o, m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o);
    else pass_cnt++;
    s_cyc = 1'b0; s_stb = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    access(8'h05, 8'h00, 1'b0, 4'b0001, term, rdat, ncyc);
    total_cnt++;
    if ({term, rdat} !== {3'b100, 8'h00})
      $display("FAIL mid_reset_ctrl: got term=%b dat=%h want term=100 dat=00", term, rdat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fwd_write();
    test_fwd_read();
    test_timeout();
    test_err();
    test_irq_ctrl();
    test_saturate();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
